// File: rtl/conv_csr_bank.sv
// MMIO control/status register bank for the convolution accelerator:
// NUM_CFG config words, CTRL/STATUS, start/run/done sequencer, read-to-clear flags and interrupt.
module conv_csr_bank #(
   parameter int unsigned DWIDTH    = 32,
   parameter logic [31:0] BASE_ADDR = 32'h8000_0040,
   parameter int unsigned NUM_CFG   = 4
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      wr_en_i,
   input  logic                      rd_en_i,
   input  logic [31:0]               addr_i,
   input  logic [DWIDTH-1:0]         wdata_i,
   output logic [DWIDTH-1:0]         rdata_o,
   output logic                      rvalid_o,
   output logic [NUM_CFG*DWIDTH-1:0] cfg_o,
   output logic                      start_o,
   input  logic                      idle_i,
   input  logic                      done_i,
   output logic                      irq_o
);

   localparam int unsigned CFG_IW      = (NUM_CFG > 1) ? $clog2(NUM_CFG) : 1;
   localparam logic [31:0] CTRL_ADDR   = BASE_ADDR + 32'(4 * NUM_CFG);
   localparam logic [31:0] STATUS_ADDR = CTRL_ADDR + 32'd4;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_RUN,
      ST_DONE
   } state_e;

   state_e              state_q, state_d;
   logic [DWIDTH-1:0]   cfg_q [NUM_CFG];
   logic [DWIDTH-1:0]   cfg_d [NUM_CFG];
   logic [DWIDTH-1:0]   rdata_q, rdata_d;
   logic                rvalid_q, rvalid_d;
   logic                start_q, start_d;
   logic                irq_q, irq_d;
   logic                irq_en_q, irq_en_d;
   logic                done_sticky_q, done_sticky_d;
   logic                err_q, err_d;

   logic                aligned, cfg_hit, ctrl_hit, status_hit, start_req;
   logic [CFG_IW-1:0]   cfg_idx;
   logic [DWIDTH-1:0]   rd_val;

   // Address decode: only exact, word-aligned matches hit.
   always_comb begin
      aligned    = (addr_i[1:0] == 2'b00);
      ctrl_hit   = aligned && (addr_i == CTRL_ADDR);
      status_hit = aligned && (addr_i == STATUS_ADDR);
      cfg_hit    = 1'b0;
      cfg_idx    = '0;
      for (int i = 0; i < NUM_CFG; i++) begin
         if (aligned && (addr_i == BASE_ADDR + 32'(4 * i))) begin
            cfg_hit = 1'b1;
            cfg_idx = CFG_IW'(i);
         end
      end
      start_req = wr_en_i && ctrl_hit && wdata_i[0];
   end

   always_comb begin
      rd_val = '0;
      if (cfg_hit) begin
         rd_val = cfg_q[cfg_idx];
      end else if (ctrl_hit) begin
         rd_val[1] = irq_en_q;
      end else if (status_hit) begin
         rd_val[4:0] = {err_q, irq_en_q, done_sticky_q, (state_q == ST_RUN), idle_i};
      end
   end

   // NOTE: every signal written here gets a default first, so no path leaves it unassigned and no latch is inferred.
   always_comb begin
      state_d       = state_q;
      cfg_d         = cfg_q;
      start_d       = 1'b0;
      irq_en_d      = irq_en_q;
      done_sticky_d = done_sticky_q;
      err_d         = err_q;
      rvalid_d      = rd_en_i;
      rdata_d       = rd_en_i ? rd_val : rdata_q;

      // Clears come first so any set later in this block wins over read-to-clear.
      if (rd_en_i && status_hit) begin
         done_sticky_d = 1'b0;
         err_d         = 1'b0;
      end
      if (wr_en_i && ctrl_hit) begin
         irq_en_d = wdata_i[1];
      end
      if (wr_en_i && cfg_hit) begin
         if (state_q == ST_RUN) begin
            err_d = 1'b1;
         end else begin
            cfg_d[cfg_idx] = wdata_i;
         end
      end

      case (state_q)
         ST_RUN: begin
            if (start_req) begin
               err_d = 1'b1;
            end
            if (done_i) begin
               state_d       = ST_DONE;
               done_sticky_d = 1'b1;
            end
         end
         default: begin
            if (start_req) begin
               state_d       = ST_RUN;
               start_d       = 1'b1;
               done_sticky_d = 1'b0;
            end
         end
      endcase

      irq_d = done_sticky_q & irq_en_q;
   end

   // NOTE: state uses non-blocking assignments so every register samples the pre-edge values.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q       <= ST_IDLE;
         // NOTE: the config words are reset too; the engine may be started before software programs them.
         cfg_q         <= '{default: '0};
         rdata_q       <= '0;
         rvalid_q      <= 1'b0;
         start_q       <= 1'b0;
         irq_q         <= 1'b0;
         irq_en_q      <= 1'b0;
         done_sticky_q <= 1'b0;
         err_q         <= 1'b0;
      end else begin
         state_q       <= state_d;
         cfg_q         <= cfg_d;
         rdata_q       <= rdata_d;
         rvalid_q      <= rvalid_d;
         start_q       <= start_d;
         irq_q         <= irq_d;
         irq_en_q      <= irq_en_d;
         done_sticky_q <= done_sticky_d;
         err_q         <= err_d;
      end
   end

   for (genvar g = 0; g < NUM_CFG; g++) begin : g_cfg_out
      assign cfg_o[g*DWIDTH +: DWIDTH] = cfg_q[g];
   end

   assign rdata_o  = rdata_q;
   assign rvalid_o = rvalid_q;
   assign start_o  = start_q;
   assign irq_o    = irq_q;

endmodule

// File: tb/tb_conv_csr_bank.sv
// Directed bench for conv_csr_bank: inputs driven and outputs sampled on the falling edge.
module tb_conv_csr_bank;

   localparam logic [31:0] CFG0   = 32'h8000_0040;
   localparam logic [31:0] CTRL   = 32'h8000_0050;
   localparam logic [31:0] STATUS = 32'h8000_0054;

   logic          clk = 1'b0;
   logic          rst;
   logic          wr_en, rd_en;
   logic [31:0]   addr, wdata, rdata;
   logic          rvalid, start, idle, done, irq;
   logic [127:0]  cfg;

   int checks   = 0;
   int failures = 0;
   logic [31:0] exp_cfg [4];

   always #5 clk = ~clk;

   conv_csr_bank dut (
      .clk      (clk),
      .rst      (rst),
      .wr_en_i  (wr_en),
      .rd_en_i  (rd_en),
      .addr_i   (addr),
      .wdata_i  (wdata),
      .rdata_o  (rdata),
      .rvalid_o (rvalid),
      .cfg_o    (cfg),
      .start_o  (start),
      .idle_i   (idle),
      .done_i   (done),
      .irq_o    (irq)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic mmio_wr(input logic [31:0] a, input logic [31:0] d);
      wr_en = 1'b1; addr = a; wdata = d;
      @(negedge clk);
      wr_en = 1'b0; addr = '0; wdata = '0;
   endtask

   task automatic mmio_rd(input string tag, input logic [31:0] a, input logic [31:0] exp);
      rd_en = 1'b1; addr = a;
      @(negedge clk);
      rd_en = 1'b0; addr = '0;
      check({tag, "_rvalid"}, 32'(rvalid), 32'd1);
      check(tag, rdata, exp);
   endtask

   task automatic pulse_done();
      done = 1'b1;
      @(negedge clk);
      done = 1'b0;
   endtask

   task automatic check_cfg(input string tag);
      for (int i = 0; i < 4; i++) begin
         check($sformatf("%s_cfg%0d", tag, i), cfg[i*32 +: 32], exp_cfg[i]);
      end
   endtask

   initial begin
      rst = 1'b1; wr_en = 1'b0; rd_en = 1'b0; addr = '0; wdata = '0;
      idle = 1'b1; done = 1'b0;
      exp_cfg = '{default: '0};
      repeat (2) @(negedge clk);
      check("rst_rvalid", 32'(rvalid), 32'd0);
      check("rst_rdata", rdata, 32'd0);
      check("rst_start", 32'(start), 32'd0);
      check("rst_irq", 32'(irq), 32'd0);
      check_cfg("rst");
      rst = 1'b0;
      @(negedge clk);

      // 1: every mapped address reads zero after reset
      for (int i = 0; i < 4; i++) mmio_rd($sformatf("rd0_cfg%0d", i), CFG0 + 32'(4 * i), 32'd0);
      mmio_rd("rd0_ctrl", CTRL, 32'd0);
      mmio_rd("rd0_status", STATUS, 32'h01);
      @(negedge clk);
      check("rvalid_one_cycle", 32'(rvalid), 32'd0);
      check("rdata_hold", rdata, 32'h01);

      // 2: config writes and read-back
      exp_cfg = '{32'h100, 32'h200, 32'h1C, 32'h300};
      for (int i = 0; i < 4; i++) begin
         mmio_wr(CFG0 + 32'(4 * i), exp_cfg[i]);
         check($sformatf("wr_cfg%0d_out", i), cfg[i*32 +: 32], exp_cfg[i]);
      end
      for (int i = 0; i < 4; i++) mmio_rd($sformatf("rb_cfg%0d", i), CFG0 + 32'(4 * i), exp_cfg[i]);
      mmio_rd("rd_misaligned", CFG0 + 32'd1, 32'd0);
      mmio_wr(CFG0 + 32'd2, 32'hBAD);
      mmio_wr(CFG0 - 32'd4, 32'hBAD);
      mmio_wr(STATUS, 32'hFFFF_FFFF);
      check_cfg("unmapped_wr");
      mmio_rd("status_after_ro_wr", STATUS, 32'h01);

      // simultaneous read and write of cfg1: old value returned, new value stored
      rd_en = 1'b1; wr_en = 1'b1; addr = CFG0 + 32'd4; wdata = 32'h222;
      @(negedge clk);
      rd_en = 1'b0; wr_en = 1'b0; addr = '0; wdata = '0;
      check("rdwr_rdata", rdata, 32'h200);
      exp_cfg[1] = 32'h222;
      check_cfg("rdwr");

      // 3: start, busy, write protection
      mmio_wr(CTRL, 32'h3);
      check("start_pulse", 32'(start), 32'd1);
      idle = 1'b0;
      @(negedge clk);
      check("start_one_cycle", 32'(start), 32'd0);
      mmio_rd("status_busy", STATUS, 32'h0A);
      mmio_wr(CFG0, 32'hDEAD);
      check_cfg("wr_protect");
      mmio_rd("ctrl_rd", CTRL, 32'h02);

      // 4: completion, interrupt, read-to-clear
      pulse_done();
      check("irq_lag", 32'(irq), 32'd0);
      @(negedge clk);
      check("irq_rise", 32'(irq), 32'd1);
      mmio_rd("status_done", STATUS, 32'h1C);
      mmio_rd("status_cleared", STATUS, 32'h08);
      check("irq_fall", 32'(irq), 32'd0);

      // 5a: done_i coincident with a STATUS read
      mmio_wr(CTRL, 32'h3);
      check("restart_pulse", 32'(start), 32'd1);
      rd_en = 1'b1; addr = STATUS; done = 1'b1;
      @(negedge clk);
      rd_en = 1'b0; addr = '0; done = 1'b0;
      check("coinc_rdata", rdata, 32'h0A);
      mmio_rd("coinc_sticky", STATUS, 32'h0C);
      mmio_wr(CFG0 + 32'd8, 32'h55);
      exp_cfg[2] = 32'h55;
      check_cfg("wr_in_done");

      // 5b: start request during RUN
      mmio_wr(CTRL, 32'h3);
      check("run_start_pulse", 32'(start), 32'd1);
      mmio_wr(CTRL, 32'h3);
      check("no_pulse_in_run", 32'(start), 32'd0);
      @(negedge clk);
      check("no_pulse_late", 32'(start), 32'd0);
      mmio_rd("status_start_err", STATUS, 32'h1A);

      // 5c: done_i outside RUN is ignored
      pulse_done();
      mmio_rd("status_done2", STATUS, 32'h0C);
      pulse_done();
      mmio_rd("done_in_done_ignored", STATUS, 32'h08);

      // 6: reset during RUN with irq high
      mmio_wr(CTRL, 32'h3);
      pulse_done();
      @(negedge clk);
      check("pre_rst_irq", 32'(irq), 32'd1);
      mmio_wr(CTRL, 32'h3);
      check("pre_rst_start", 32'(start), 32'd1);
      check("pre_rst_irq_run", 32'(irq), 32'd1);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      idle = 1'b1;
      check("rst2_start", 32'(start), 32'd0);
      check("rst2_irq", 32'(irq), 32'd0);
      check("rst2_rvalid", 32'(rvalid), 32'd0);
      check("rst2_rdata", rdata, 32'd0);
      exp_cfg = '{default: '0};
      check_cfg("rst2");
      mmio_rd("rst2_status", STATUS, 32'h01);
      pulse_done();
      mmio_rd("done_in_idle_ignored", STATUS, 32'h01);
      mmio_wr(CTRL, 32'h1);
      check("post_rst_start", 32'(start), 32'd1);
      idle = 1'b0;
      mmio_rd("post_rst_busy", STATUS, 32'h02);
      pulse_done();
      repeat (2) @(negedge clk);
      check("irq_masked", 32'(irq), 32'd0);
      mmio_rd("post_rst_done", STATUS, 32'h04);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
